// File: rtl/pipe_reg_nbits.sv
// Purpose: DEPTH-stage elastic pipeline register with per-stage valid, bubble collapsing, flush, occupancy.
// Latency: DEPTH cycles from input transfer to valid_o when empty and ready_i=1; 1 transfer/cycle.
// Backpressure: empty stages keep filling under ready_i=0; ready_o drops only when every stage is valid and stalled.
//
// Ports:
//   clock_i      rising-edge clock
//   resetb_i     asynchronous active-low reset
//   d_i/valid_i  upstream data/valid, ready_o back to upstream
//   q_o/valid_o  data/valid of the last stage, ready_i from downstream
//   flush_i      synchronous discard of all stages (wins over advance)
//   occupancy_o  number of valid stages, 0..DEPTH
//
// Build option: define PIPE_REG_CLEAR_DATA_EN to give the data registers
// an asynchronous reset to 0 and to zero them on flush. Without it the data
// registers carry no reset and q_o is meaningless while valid_o=0.

module pipe_reg_nbits #(
    parameter int width = 8,
    parameter int DEPTH = 3
) (
    input  logic                         clock_i,
    input  logic                         resetb_i,
    input  logic [width-1:0]             d_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic [width-1:0]             q_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    input  logic                         flush_i,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [width-1:0] r_dat [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [DEPTH:0]   w_adv;
    logic [OCC_W-1:0] w_occ;

    // A stage may load when it is empty or when the stage after it moves,
    // so bubbles are squeezed out even while the output is stalled.
    always_comb begin
        w_adv        = '0;
        w_adv[DEPTH] = ready_i;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_adv[k] = ~r_vld[k] | w_adv[k+1];
        end
    end

    always_comb begin
        w_occ = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_occ = w_occ + OCC_W'(r_vld[k]);
        end
    end

    assign ready_o     = w_adv[0] & ~flush_i;
    assign q_o         = r_dat[DEPTH-1];
    assign valid_o     = r_vld[DEPTH-1];
    assign occupancy_o = w_occ;

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            r_vld <= '0;
        end else if (flush_i) begin
            r_vld <= '0;
        end else begin
            if (w_adv[0]) begin
                r_vld[0] <= valid_i;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_adv[k]) begin
                    r_vld[k] <= r_vld[k-1];
                end
            end
        end
    end

`ifdef PIPE_REG_CLEAR_DATA_EN
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_dat[k] <= '0;
            end
        end else if (flush_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_dat[k] <= '0;
            end
        end else begin
            // Stage 0 only captures on a real input transfer, so a bubble
            // does not drag a stale d_i into the pipe.
            if (w_adv[0] && valid_i) begin
                r_dat[0] <= d_i;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_adv[k]) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end
`else
    always_ff @(posedge clock_i) begin
        if (!flush_i) begin
            if (w_adv[0] && valid_i) begin
                r_dat[0] <= d_i;
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_adv[k]) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end
`endif

endmodule
